// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, the canonical NOP and the base
// RV32I opcodes used by decode and immediate generation.
package core_pkg;

    typedef enum logic [1:0] {
        HDR,
        DATA,
        RUN
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: UART byte stream and control decisions in, instruction/PC
// and core status out. The fetch stage is the slave side.
interface inst_fetch_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        load_req;
    logic        branch_taken;
    logic        jal;
    logic        jalr;
    logic [31:0] imm_value;
    logic [31:0] alu_result;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        core_en;
    logic        load_done;
    logic        misalign;

    modport master (
        output rx_valid, rx_data, load_req, branch_taken, jal, jalr, imm_value, alu_result,
        input  instruction, pc, pc_plus4, core_en, load_done, misalign
    );

    modport slave (
        input  rx_valid, rx_data, load_req, branch_taken, jal, jalr, imm_value, alu_result,
        output instruction, pc, pc_plus4, core_en, load_done, misalign
    );

endinterface

// File: rtl/inst_fetch_imem.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module inst_fetch_imem #(
    parameter int unsigned  DEPTH  = 1024,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: boots the program from a little-endian UART byte stream into
// instruction memory, then runs the PC with jalr > jal/branch > +4 priority.
module inst_fetch
    import core_pkg::*;
#(
    parameter int unsigned  IMEM_DEPTH = 1024,
    localparam int unsigned ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input logic         i_clk,
    input logic         i_rst,
    inst_fetch_if.slave io_bus
);

    fetch_state_t r_state, w_state_next;
    logic [1:0]   r_byte_cnt, w_byte_cnt_next;
    logic [23:0]  r_shift, w_shift_next;
    logic [31:0]  r_word_cnt, w_word_cnt_next;
    logic [31:0]  r_word_idx, w_word_idx_next;
    logic [31:0]  r_pc, w_pc_next;
    logic         r_misalign, w_misalign_next;
    logic         r_load_done, w_load_done_next;

    logic [31:0]  w_word;
    logic         w_word_done;
    logic         w_mem_we;
    logic [31:0]  w_mem_rdata;

    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_target;
    logic         w_redirect;
    logic [31:0]  w_next_pc;
    logic         w_target_misaligned;

    // The 4th byte is taken straight from the bus so the word is ready on its edge
    assign w_word      = {io_bus.rx_data, r_shift};
    assign w_word_done = io_bus.rx_valid && (r_byte_cnt == 2'd3);

    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_redirect = 1'b0;
        w_target   = w_pc_plus4;
        if (io_bus.jalr) begin
            w_redirect = 1'b1;
            w_target   = {io_bus.alu_result[31:1], 1'b0};
        end else if (io_bus.jal || io_bus.branch_taken) begin
            w_redirect = 1'b1;
            w_target   = r_pc + io_bus.imm_value;
        end
    end

    assign w_next_pc           = {w_target[31:2], 2'b00};
    assign w_target_misaligned = w_redirect && (w_target[1:0] != 2'b00);

    always_comb begin
        w_state_next     = r_state;
        w_byte_cnt_next  = r_byte_cnt;
        w_shift_next     = r_shift;
        w_word_cnt_next  = r_word_cnt;
        w_word_idx_next  = r_word_idx;
        w_pc_next        = r_pc;
        w_misalign_next  = r_misalign;
        w_load_done_next = 1'b0;
        w_mem_we         = 1'b0;

        unique case (r_state)
            HDR: begin
                if (io_bus.rx_valid) begin
                    w_shift_next    = {io_bus.rx_data, r_shift[23:8]};
                    w_byte_cnt_next = r_byte_cnt + 2'd1;
                end
                // A zero word count leaves us waiting for the next header
                if (w_word_done && (w_word != 32'd0)) begin
                    w_word_cnt_next = w_word;
                    w_word_idx_next = 32'd0;
                    w_misalign_next = 1'b0;
                    w_state_next    = DATA;
                end
            end
            DATA: begin
                if (io_bus.rx_valid) begin
                    w_shift_next    = {io_bus.rx_data, r_shift[23:8]};
                    w_byte_cnt_next = r_byte_cnt + 2'd1;
                end
                if (w_word_done) begin
                    w_mem_we        = (r_word_idx < IMEM_DEPTH);
                    w_word_idx_next = r_word_idx + 32'd1;
                    if ((r_word_idx + 32'd1) == r_word_cnt) begin
                        w_pc_next        = 32'd0;
                        w_load_done_next = 1'b1;
                        w_state_next     = RUN;
                    end
                end
            end
            RUN: begin
                if (io_bus.load_req) begin
                    w_byte_cnt_next = 2'd0;
                    w_state_next    = HDR;
                end else begin
                    w_pc_next = w_next_pc;
                    if (w_target_misaligned) begin
                        w_misalign_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = HDR;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= HDR;
            r_byte_cnt  <= 2'd0;
            r_shift     <= 24'd0;
            r_word_cnt  <= 32'd0;
            r_word_idx  <= 32'd0;
            r_pc        <= 32'd0;
            r_misalign  <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_byte_cnt  <= w_byte_cnt_next;
            r_shift     <= w_shift_next;
            r_word_cnt  <= w_word_cnt_next;
            r_word_idx  <= w_word_idx_next;
            r_pc        <= w_pc_next;
            r_misalign  <= w_misalign_next;
            r_load_done <= w_load_done_next;
        end
    end

    inst_fetch_imem #(
        .DEPTH (IMEM_DEPTH)
    ) u_imem (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_waddr (r_word_idx[ADDR_W-1:0]),
        .i_wdata (w_word),
        .i_raddr (r_pc[ADDR_W+1:2]),
        .o_rdata (w_mem_rdata)
    );

    assign io_bus.instruction = (r_state == RUN) ? w_mem_rdata : NOP_INSTR;
    assign io_bus.pc          = r_pc;
    assign io_bus.pc_plus4    = w_pc_plus4;
    assign io_bus.core_en     = (r_state == RUN);
    assign io_bus.load_done   = r_load_done;
    assign io_bus.misalign    = r_misalign;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: vector table for next-PC selection,
// hand sequences for load corner cases, random run against a reference model.
module tb_inst_fetch;
    import core_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_if bus ();

    inst_fetch #(
        .IMEM_DEPTH (DEPTH)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [31:0] m_pc;
    bit          m_mis;

    typedef struct {
        bit          br;
        bit          jal;
        bit          jalr;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] exp_pc;
        bit          exp_mis;
    } vec_t;

    vec_t vecs [10];
    logic [7:0] plan [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        bus.load_req = 1'b0;
        bus.branch_taken = 1'b0;
        bus.jal = 1'b0;
        bus.jalr = 1'b0;
        bus.imm_value = 32'h0;
        bus.alu_result = 32'h0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_header(input logic [31:0] n);
        send_word(n);
        if (n != 32'd0) m_mis = 1'b0;
    endtask

    task automatic load_word(input int idx, input logic [31:0] w);
        send_word(w);
        if (idx < DEPTH) begin
            m_mem[idx] = w;
            m_known[idx] = 1'b1;
        end
    endtask

    task automatic check_loaded(input string tag);
        m_pc = 32'd0;
        check({tag, " core_en"}, 32'(bus.core_en), 32'd1);
        check({tag, " load_done"}, 32'(bus.load_done), 32'd1);
        check({tag, " pc"}, bus.pc, 32'd0);
    endtask

    task automatic check_run(input string tag);
        int wi;
        wi = int'((m_pc >> 2) % DEPTH);
        check({tag, " pc"}, bus.pc, m_pc);
        check({tag, " pc_plus4"}, bus.pc_plus4, m_pc + 32'd4);
        check({tag, " misalign"}, 32'(bus.misalign), 32'(m_mis));
        check({tag, " core_en"}, 32'(bus.core_en), 32'd1);
        if (m_known[wi]) check({tag, " instruction"}, bus.instruction, m_mem[wi]);
    endtask

    task automatic run_step(input bit br, input bit jal, input bit jalr,
                            input logic [31:0] imm, input logic [31:0] alu, input string tag);
        logic [31:0] t;
        bus.branch_taken = br;
        bus.jal = jal;
        bus.jalr = jalr;
        bus.imm_value = imm;
        bus.alu_result = alu;
        if (jalr) t = alu & ~32'h1;
        else if (jal || br) t = m_pc + imm;
        else t = m_pc + 32'd4;
        if (t % 4 != 0) m_mis = 1'b1;
        m_pc = t & ~32'h3;
        tick();
        clear_ctrl();
        check_run(tag);
    endtask

    // load_req with a competing jal: the reload wins and pc must hold
    task automatic req_reload(input string tag);
        bus.load_req = 1'b1;
        bus.jal = 1'b1;
        bus.imm_value = 32'h40;
        tick();
        clear_ctrl();
        check({tag, " core_en"}, 32'(bus.core_en), 32'd0);
        check({tag, " pc held"}, bus.pc, m_pc);
        check({tag, " nop"}, bus.instruction, NOP_INSTR);
    endtask

    initial begin
        logic [31:0] r, imm, alu;
        int kind;

        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        m_pc = 32'd0;
        m_mis = 1'b0;
        clear_ctrl();

        plan = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                 8'h93, 8'h05, 8'h20, 8'h00};
        vecs[0] = '{0, 0, 0, 32'h0, 32'h0, 32'h4, 0};
        vecs[1] = '{0, 0, 0, 32'h0, 32'h0, 32'h8, 0};
        vecs[2] = '{1, 0, 0, 32'hFFFF_FFF8, 32'h0, 32'h0, 0};
        vecs[3] = '{0, 0, 0, 32'h0, 32'h0, 32'h4, 0};
        vecs[4] = '{0, 1, 1, 32'h40, 32'h101, 32'h100, 0};
        vecs[5] = '{0, 1, 0, 32'h6, 32'h0, 32'h104, 1};
        vecs[6] = '{1, 0, 0, 32'h10, 32'h0, 32'h114, 1};
        vecs[7] = '{0, 0, 1, 32'h0, 32'h3, 32'h0, 1};
        vecs[8] = '{0, 1, 0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1};
        vecs[9] = '{0, 0, 0, 32'h0, 32'h0, 32'h0, 1};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset pc", bus.pc, 32'h0);
        check("reset pc_plus4", bus.pc_plus4, 32'h4);
        check("reset instruction", bus.instruction, NOP_INSTR);
        check("reset core_en", 32'(bus.core_en), 32'd0);
        check("reset load_done", 32'(bus.load_done), 32'd0);
        check("reset misalign", 32'(bus.misalign), 32'd0);

        // Byte stream from the plan, literally
        for (int i = 0; i < 12; i++) begin
            if (i == 11) check("plan core_en before last", 32'(bus.core_en), 32'd0);
            send_byte(plan[i]);
        end
        m_mem[0] = 32'h0010_0513;
        m_mem[1] = 32'h0020_0593;
        m_known[0] = 1'b1;
        m_known[1] = 1'b1;
        check_loaded("plan");
        check("plan instr0", bus.instruction, 32'h0010_0513);

        for (int i = 0; i < 10; i++) begin
            run_step(vecs[i].br, vecs[i].jal, vecs[i].jalr, vecs[i].imm, vecs[i].alu, "vec");
            check($sformatf("vec%0d pc", i), bus.pc, vecs[i].exp_pc);
            check($sformatf("vec%0d mis", i), 32'(bus.misalign), 32'(vecs[i].exp_mis));
            if (i == 0) check("vec0 instr1", bus.instruction, 32'h0020_0593);
            if (i == 0) check("vec0 load_done low", 32'(bus.load_done), 32'd0);
        end

        // Reload 18 words into a 16-word memory: the last two are discarded
        run_step(0, 0, 0, 32'h0, 32'h0, "pre-reload");
        req_reload("reload");
        send_header(32'd18);
        check("reload mis cleared", 32'(bus.misalign), 32'd0);
        for (int i = 0; i < 18; i++) begin
            if (i == 17) check("reload core_en before last", 32'(bus.core_en), 32'd0);
            load_word(i, $urandom);
        end
        check_loaded("reload");
        check_run("reload run");

        for (int n = 0; n < 200; n++) begin
            r = $urandom;
            kind = $urandom_range(0, 7);
            imm = {{22{r[9]}}, r[9:2], (r[12:10] == 3'd0) ? r[1:0] : 2'b00};
            alu = {24'h0, r[20:13]};
            if (r[23:21] != 3'd0) alu[1:0] = 2'b00;
            bus.rx_valid = r[24];
            bus.rx_data = r[31:24];
            run_step(kind == 3 || kind == 7, kind == 4 || kind == 7, kind == 5,
                     imm, alu, "rand");
        end

        // Zero header must be ignored and not clear misalign
        req_reload("zh");
        send_header(32'd0);
        check("zh core_en", 32'(bus.core_en), 32'd0);
        check("zh mis kept", 32'(bus.misalign), 32'(m_mis));
        send_header(32'd1);
        check("zh core_en after hdr", 32'(bus.core_en), 32'd0);
        load_word(0, 32'hDEAD_BEEF);
        check_loaded("zh");
        check("zh instr", bus.instruction, 32'hDEAD_BEEF);
        run_step(0, 0, 0, 32'h0, 32'h0, "zh step");

        // Reset mid-load after two words and a partial third
        req_reload("rst");
        send_header(32'd3);
        load_word(0, 32'h1111_1111);
        load_word(1, 32'h2222_2222);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_pc = 32'd0;
        m_mis = 1'b0;
        check("rst core_en", 32'(bus.core_en), 32'd0);
        check("rst nop", bus.instruction, NOP_INSTR);
        check("rst pc", bus.pc, 32'h0);
        send_header(32'd1);
        load_word(0, 32'h3333_3333);
        check_loaded("rst");
        check("rst instr0", bus.instruction, 32'h3333_3333);
        run_step(0, 0, 0, 32'h0, 32'h0, "rst step");
        check("rst retained word1", bus.instruction, 32'h2222_2222);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
